obj_shift_lbuf: RTL

- Object pixel stage directly downstream of the A5004-1 timing PAL.
- Consumes its PLOAD_RSHIFTn, RL_Sel, AB_Sel, VDG and G15_CE outputs.
- Parallel-loads 4-plane object ROM bytes into a shifter and serialises 4bpp pixels with horizontal flip.
- Writes opaque pixels into one half of an external A/B ping-pong line buffer while reading out and erasing the other half for display.

---
 rtl/obj_shift_lbuf.sv | 138 +++++++++++++
 1 files changed

// File: rtl/obj_shift_lbuf.sv
// Object pixel stage: serialises 4-plane ROM bytes into pixels (with horizontal flip) and
// writes opaque pixels into one half of an A/B line buffer while displaying and erasing the other.
module obj_shift_lbuf #(
  parameter int XW    = 9,
  parameter int PIXW  = 4,
  parameter int BANKW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cen,
  input  logic                  pload_rshiftn,
  input  logic                  rl_sel,
  input  logic                  ab_sel,
  input  logic                  vdg,
  input  logic                  g15_ce,
  input  logic                  x_load,
  input  logic [XW-1:0]         x_start,
  input  logic [PIXW*8-1:0]     rom_data,
  input  logic [BANKW-1:0]      bank,
  input  logic [XW-1:0]         hcount,
  output logic                  lb_a_we,
  output logic [XW-1:0]         lb_a_addr,
  output logic [BANKW+PIXW-1:0] lb_a_wdata,
  input  logic [BANKW+PIXW-1:0] lb_a_rdata,
  output logic                  lb_b_we,
  output logic [XW-1:0]         lb_b_addr,
  output logic [BANKW+PIXW-1:0] lb_b_wdata,
  input  logic [BANKW+PIXW-1:0] lb_b_rdata,
  output logic [BANKW+PIXW-1:0] obj_pix
);

  localparam int DW = BANKW + PIXW;

  logic [PIXW*8-1:0] shifter, shifter_nx;
  logic [BANKW-1:0]  bank_q;
  logic              flip_q;
  logic [3:0]        remaining;
  logic [XW-1:0]     xcnt;
  logic [PIXW-1:0]   pixel;

  // Registered write requests; sel encodes the target buffer (0 = A, 1 = B).
  logic              sp_v, sp_sel;
  logic [XW-1:0]     sp_addr;
  logic [DW-1:0]     sp_data;
  logic              er_v, er_sel;
  logic [XW-1:0]     er_addr;
  logic              disp_sel, rd_valid;
  logic [XW-1:0]     disp_addr;

  logic do_load, do_shift, issue;
  logic a_sp, b_sp, a_er, b_er;

  // flip_q=1 takes bit 7 of each plane and shifts left; flip_q=0 takes bit 0 and shifts right.
  always_comb begin
    pixel      = '0;
    shifter_nx = '0;
    for (int p = 0; p < PIXW; p++) begin
      if (remaining != 4'd0)
        pixel[p] = flip_q ? shifter[8*p+7] : shifter[8*p];
      shifter_nx[8*p +: 8] = flip_q ? {shifter[8*p +: 7], 1'b0}
                                    : {1'b0, shifter[8*p+1 +: 7]};
    end
  end

  assign do_load  = cen & ~pload_rshiftn;
  assign do_shift = cen &  pload_rshiftn;
  assign issue    = do_shift & vdg & (pixel != '0);

  // NOTE: every register below uses <= so all updates see pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter   <= '0;
      bank_q    <= '0;
      flip_q    <= 1'b0;
      remaining <= '0;
      xcnt      <= '0;
      sp_v      <= 1'b0;
      sp_sel    <= 1'b0;
      sp_addr   <= '0;
      sp_data   <= '0;
      er_v      <= 1'b0;
      er_sel    <= 1'b0;
      er_addr   <= '0;
      disp_sel  <= 1'b0;
      disp_addr <= '0;
      rd_valid  <= 1'b0;
      obj_pix   <= '0;
    end else begin
      if (do_load) begin
        shifter   <= rom_data;
        bank_q    <= bank;
        flip_q    <= rl_sel;
        remaining <= 4'd8;
      end else if (do_shift && remaining != 4'd0) begin
        shifter   <= shifter_nx;
        remaining <= remaining - 4'd1;
      end

      if (cen) begin
        if (x_load)      xcnt <= x_start;
        else if (g15_ce) xcnt <= xcnt + 1'b1;
      end

      // Strobes are one clk wide regardless of the cen rate.
      sp_v <= issue;
      if (issue) begin
        sp_sel  <= ab_sel;
        sp_addr <= xcnt;
        sp_data <= {bank_q, pixel};
      end

      // Erase lands in the clk after obj_pix captures the slot being erased.
      er_v <= cen & rd_valid;
      if (cen) begin
        er_sel    <= disp_sel;
        er_addr   <= disp_addr;
        disp_sel  <= ~ab_sel;
        disp_addr <= hcount;
        rd_valid  <= 1'b1;
        if (rd_valid) obj_pix <= disp_sel ? lb_b_rdata : lb_a_rdata;
      end
    end
  end

  // A sprite write to the buffer being erased wins; that erase is dropped.
  assign a_sp = sp_v & ~sp_sel;
  assign b_sp = sp_v &  sp_sel;
  assign a_er = er_v & ~er_sel & ~a_sp;
  assign b_er = er_v &  er_sel & ~b_sp;

  assign lb_a_we    = a_sp | a_er;
  assign lb_a_addr  = a_sp ? sp_addr : (a_er ? er_addr : disp_addr);
  assign lb_a_wdata = a_sp ? sp_data : '0;
  assign lb_b_we    = b_sp | b_er;
  assign lb_b_addr  = b_sp ? sp_addr : (b_er ? er_addr : disp_addr);
  assign lb_b_wdata = b_sp ? sp_data : '0;

endmodule
